// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, ASCII constants, hex-writer FSM encoding.
// Optional "0x" word prefix is enabled by defining UART_HEX_PREFIX_EN.
package uart_pkg;

    localparam logic [1:0] UART_ADDR_TX  = 2'b00;
    localparam logic [1:0] UART_ADDR_RX  = 2'b01;
    localparam logic [1:0] UART_ADDR_DIV = 2'b10;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_X    = 8'h78;

`ifdef UART_HEX_PREFIX_EN
    localparam int PREFIX_CHARS = 2;
`else
    localparam int PREFIX_CHARS = 0;
`endif

    // Eight hex digits plus CR and LF, after any prefix characters.
    localparam int         CHARS_PER_WORD = PREFIX_CHARS + 10;
    localparam logic [3:0] LF_IDX         = 4'(CHARS_PER_WORD - 1);
    localparam logic [3:0] CR_IDX         = 4'(CHARS_PER_WORD - 2);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_REL,
        ST_GAP
    } hex_writer_state_t;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
module hex_nibble_ascii
    import uart_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = ASCII_A + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/uart_hex_writer.sv
// Prints 32-bit words as uppercase hex + CR/LF through the UART slave bus, paced by a fixed gap.
// Define UART_HEX_PREFIX_EN to precede every word with "0x".
module uart_hex_writer
    import uart_pkg::*;
#(
    parameter int DIVIDER     = 78,
    parameter int GAP_CYCLES  = 12640,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        busy,
    output logic        err,
    output logic [1:0]  wbm_addr,
    output logic [7:0]  wbm_data_out,
    output logic        wbm_we,
    output logic        wbm_stb,
    output logic        wbm_clk,
    input  logic        wbm_ack
);

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [7:0]  TMO_LAST = 8'(ACK_TIMEOUT - 1);

    hex_writer_state_t state_reg, state_next;
    logic [31:0] shift_reg, shift_next;
    logic [3:0]  char_idx_reg, char_idx_next;
    logic [15:0] gap_cnt_reg, gap_cnt_next;
    logic [7:0]  tmo_cnt_reg, tmo_cnt_next;
    logic        is_div_reg, is_div_next;
    logic [1:0]  addr_reg, addr_next;
    logic [7:0]  data_reg, data_next;
    logic        err_reg, err_next;

    logic [7:0]  hex_char;
    logic [7:0]  load_char;
    logic        load_is_hex;

    hex_nibble_ascii u_hex (
        .nibble (shift_reg[31:28]),
        .ascii  (hex_char)
    );

    // Character chosen for the current char_idx; only hex digits consume a nibble.
    always_comb begin
        load_char   = hex_char;
        load_is_hex = 1'b1;
`ifdef UART_HEX_PREFIX_EN
        if (char_idx_reg == 4'd0) begin
            load_char   = ASCII_ZERO;
            load_is_hex = 1'b0;
        end else if (char_idx_reg == 4'd1) begin
            load_char   = ASCII_X;
            load_is_hex = 1'b0;
        end
`endif
        if (char_idx_reg == CR_IDX) begin
            load_char   = ASCII_CR;
            load_is_hex = 1'b0;
        end else if (char_idx_reg == LF_IDX) begin
            load_char   = ASCII_LF;
            load_is_hex = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_INIT;
            shift_reg    <= '0;
            char_idx_reg <= '0;
            gap_cnt_reg  <= '0;
            tmo_cnt_reg  <= '0;
            is_div_reg   <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            char_idx_reg <= char_idx_next;
            gap_cnt_reg  <= gap_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            is_div_reg   <= is_div_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        char_idx_next = char_idx_reg;
        gap_cnt_next  = gap_cnt_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        is_div_next   = is_div_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        err_next      = 1'b0;

        case (state_reg)
            ST_INIT: begin
                addr_next    = UART_ADDR_DIV;
                data_next    = 8'(DIVIDER);
                is_div_next  = 1'b1;
                tmo_cnt_next = '0;
                if (!wbm_ack) begin
                    state_next = ST_REQ;
                end
            end

            ST_IDLE: begin
                if (in_valid) begin
                    shift_next    = in_data;
                    char_idx_next = '0;
                    state_next    = ST_LOAD;
                end
            end

            ST_LOAD: begin
                addr_next    = UART_ADDR_TX;
                data_next    = load_char;
                is_div_next  = 1'b0;
                tmo_cnt_next = '0;
                if (load_is_hex) begin
                    shift_next = {shift_reg[27:0], 4'h0};
                end
                state_next = ST_REQ;
            end

            // The first REQ cycle ignores ack so a stale high level cannot complete the write.
            ST_REQ: begin
                if (wbm_ack && (tmo_cnt_reg != 8'd0)) begin
                    tmo_cnt_next = '0;
                    state_next   = ST_REL;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 8'd1;
                end
            end

            ST_REL: begin
                if (!wbm_ack) begin
                    gap_cnt_next = '0;
                    state_next   = is_div_reg ? ST_IDLE : ST_GAP;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 8'd1;
                end
            end

            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    if (char_idx_reg == LF_IDX) begin
                        state_next = ST_IDLE;
                    end else begin
                        char_idx_next = char_idx_reg + 4'd1;
                        state_next    = ST_LOAD;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + 16'd1;
                end
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign in_ready     = (state_reg == ST_IDLE);
    assign busy         = (state_reg != ST_IDLE);
    assign err          = err_reg;
    assign wbm_addr     = addr_reg;
    assign wbm_data_out = data_reg;
    assign wbm_we       = 1'b0;
    assign wbm_stb      = (state_reg == ST_REQ);
    assign wbm_clk      = (state_reg == ST_REQ);

endmodule

// File: tb/tb_uart_hex_writer.sv
// Self-checking bench for uart_hex_writer: ack-after-2-cycles slave model plus bus-write scoreboard.
module tb_uart_hex_writer;

    localparam int GAP = 20;
    localparam int TMO = 255;
    localparam int DIV = 78;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        busy;
    logic        err;
    logic [1:0]  wbm_addr;
    logic [7:0]  wbm_data_out;
    logic        wbm_we;
    logic        wbm_stb;
    logic        wbm_clk;
    logic        wbm_ack = 1'b0;

    uart_hex_writer #(
        .DIVIDER     (DIV),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .busy         (busy),
        .err          (err),
        .wbm_addr     (wbm_addr),
        .wbm_data_out (wbm_data_out),
        .wbm_we       (wbm_we),
        .wbm_stb      (wbm_stb),
        .wbm_clk      (wbm_clk),
        .wbm_ack      (wbm_ack)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [9:0]  exp_q[$];
    logic        slave_en = 1'b1;
    int          req_cnt = 0;

    always @(posedge clk) cyc++;

    // Slave: raise ack on the second cycle of a request, drop it as soon as the request is released.
    always @(posedge clk) begin
        if (reset || !slave_en) begin
            wbm_ack <= 1'b0;
            req_cnt <= 0;
        end else if (wbm_stb && wbm_clk) begin
            if (req_cnt >= 1) wbm_ack <= 1'b1;
            req_cnt <= req_cnt + 1;
        end else begin
            wbm_ack <= 1'b0;
            req_cnt <= 0;
        end
    end

    // Monitor: every new strobe is one bus write, checked against the scoreboard head.
    logic       stb_prev = 1'b0;
    int         last_tx = -1;
    logic [9:0] exp_w;
    always @(negedge clk) begin
        if (reset) begin
            stb_prev = 1'b0;
            last_tx  = -1;
        end else begin
            if (err) last_tx = -1;
            if (wbm_stb && !stb_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_write unexpected actual addr=%0h data=%02h required none", wbm_addr, wbm_data_out);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({wbm_addr, wbm_data_out} !== exp_w) begin
                        errors++;
                        $display("FAIL bus_write actual addr=%0h data=%02h required addr=%0h data=%02h",
                                 wbm_addr, wbm_data_out, exp_w[9:8], exp_w[7:0]);
                    end else begin
                        $display("write addr=%0h data=%02h we=%0b cycle=%0d ok", wbm_addr, wbm_data_out, wbm_we, cyc);
                    end
                end
                if (wbm_addr == 2'b00 && last_tx >= 0) begin
                    checks++;
                    if (cyc - last_tx < GAP) begin
                        errors++;
                        $display("FAIL char_gap actual %0d cycles required >= %0d", cyc - last_tx, GAP);
                    end
                end
                if (wbm_addr == 2'b00) last_tx = cyc;
            end
            stb_prev = wbm_stb;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [79:0] exp, input int n);
        logic [95:0] seq;
        int          nch;
`ifdef UART_HEX_PREFIX_EN
        seq = {16'h3078, exp};
        nch = 12;
`else
        seq = {16'h0000, exp};
        nch = 10;
`endif
        for (int i = 0; i < n && i < nch; i++) begin
            exp_q.push_back({2'b00, seq[8*(nch-1-i) +: 8]});
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [79:0] exp, input int n, input string name);
        wait_ready(name);
        in_data  = w;
        in_valid = 1'b1;
        push_word(exp, n);
        @(negedge clk);
        in_valid = 1'b0;
        $display("push word=%08h (%s)", w, name);
    endtask

    task automatic wait_done(input string name);
        wait_ready(name);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [79:0] exp;
    } vec_t;

    vec_t vecs[4];
    int   cnt;

    initial begin
        vecs[0] = '{32'hDEADBEEF, 80'h44454144424545460D0A};
        vecs[1] = '{32'hFFFFFFFF, 80'h46464646464646460D0A};
        vecs[2] = '{32'h00000000, 80'h30303030303030300D0A};
        vecs[3] = '{32'h9ABCDEF0, 80'h39414243444546300D0A};

        // Reset state, then the divider write.
        exp_q.push_back({2'b10, 8'(DIV)});
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stb_clk", {30'd0, wbm_stb, wbm_clk}, 32'd0);
        check("rst_we", 32'(wbm_we), 32'd0);
        check("rst_addr_data", {22'd0, wbm_addr, wbm_data_out}, 32'd0);
        reset = 1'b0;
        wait_done("div_write");
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++) begin
            send_word(vecs[i].word, vecs[i].exp, 99, "table");
            wait_done("table");
        end

        // Second word held off until the first has been fully written.
        send_word(32'h0000000A, 80'h30303030303030410D0A, 99, "hold_first");
        in_data  = 32'h12345678;
        in_valid = 1'b1;
        push_word(80'h31323334353637380D0A, 99);
        cnt = 0;
        while (!in_ready && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
`ifdef UART_HEX_PREFIX_EN
        check("hold_off_queue", 32'(exp_q.size()), 32'd12);
`else
        check("hold_off_queue", 32'(exp_q.size()), 32'd10);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("hold_second");

        // Slave never acks: timeout abort, then normal operation resumes.
        slave_en = 1'b0;
        send_word(32'hDEADBEEF, 80'h44454144424545460D0A, 1, "no_ack");
        cnt = 0;
        while (!wbm_stb && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        while (!err && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_cycles", 32'(cnt), 32'(TMO));
        check("timeout_stb_clk", {30'd0, wbm_stb, wbm_clk}, 32'd0);
        check("timeout_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("err_one_cycle", 32'(err), 32'd0);
        slave_en = 1'b1;
        send_word(32'h12345678, 80'h31323334353637380D0A, 99, "after_timeout");
        wait_done("after_timeout");

        // Reset while the third character is on the bus.
        send_word(32'hDEADBEEF, 80'h44454144424545460D0A, 3, "mid_reset");
        cnt = 0;
        do begin
            @(negedge clk);
            #1;
            cnt++;
        end while (exp_q.size() != 0 && cnt < 3000);
        check("mid_reset_stb_high", 32'(wbm_stb), 32'd1);
        reset = 1'b1;
        exp_q.push_back({2'b10, 8'(DIV)});
        @(negedge clk);
        check("mid_reset_stb_clk", {30'd0, wbm_stb, wbm_clk}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_done("reset_div");
        repeat (60) @(negedge clk);
        check("no_stale_chars", 32'(exp_q.size()), 32'd0);
        send_word(32'h9ABCDEF0, 80'h39414243444546300D0A, 99, "post_reset");
        wait_done("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
